// File: rtl/output_classifier_pkg.sv
// Shared fixed-point definitions and the classifier state encoding.
// fixed_t is a signed Q(INTEGER_WIDTH).(FRACTION_WIDTH) score with bit
// indices [INTEGER_WIDTH-1:-FRACTION_WIDTH], so bit 0 is the units bit.
package output_classifier_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE,
    WAIT_LOW
  } classifier_state_t;

endpackage

// File: rtl/output_classifier.sv
// output_classifier: snapshots the network score array when outputs_ready
// is high, then finds the arg-max serially (one signed compare per clock).
// The winning index is offered on a valid/ready handshake.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   outputs_ready  level from the network; outputs are stable while high
//   outputs        NUM_OUTPUTS signed fixed-point scores
//   class_valid    result available, held until accepted
//   class_ready    downstream accept
//   class_index    index of the maximum score (ties keep the lowest index)
//   class_score    winning score (only when CLASSIFIER_SCORE_EN is defined)
//
// Optional feature macro: CLASSIFIER_SCORE_EN exports the winning score.
module output_classifier
  import output_classifier_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10,
  parameter int INDEX_WIDTH = ($clog2(NUM_OUTPUTS) > 0) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outputs_ready,
  input  fixed_t                 outputs [NUM_OUTPUTS],
  output logic                   class_valid,
  input  logic                   class_ready,
  output logic [INDEX_WIDTH-1:0] class_index
`ifdef CLASSIFIER_SCORE_EN
  ,
  output fixed_t                 class_score
`endif
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_OUTPUTS - 1);

  classifier_state_t      r_state;
  fixed_t                 r_snap [NUM_OUTPUTS];
  fixed_t                 r_best;
  logic [INDEX_WIDTH-1:0] r_best_idx;
  logic [INDEX_WIDTH-1:0] r_cnt;
`ifdef CLASSIFIER_SCORE_EN
  fixed_t                 r_score;
  assign class_score = r_score;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      class_valid <= 1'b0;
      class_index <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) r_snap[i] <= '0;
`ifdef CLASSIFIER_SCORE_EN
      r_score     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (outputs_ready) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) r_snap[i] <= outputs[i];
            // Element 0 seeds the running max, so the scan starts at 1.
            r_best     <= outputs[0];
            r_best_idx <= '0;
            r_cnt      <= INDEX_WIDTH'(1);
            r_state    <= (NUM_OUTPUTS == 1) ? DONE : SCAN;
          end
        end
        SCAN: begin
          // Strict '>' so an equal later score never displaces an earlier one.
          if (r_snap[r_cnt] > r_best) begin
            r_best     <= r_snap[r_cnt];
            r_best_idx <= r_cnt;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; later cycles wait for accept.
          if (!class_valid) begin
            class_valid <= 1'b1;
            class_index <= r_best_idx;
`ifdef CLASSIFIER_SCORE_EN
            r_score     <= r_best;
`endif
          end else if (class_ready) begin
            class_valid <= 1'b0;
            // Stay off until the network drops ready so one result is not
            // reported twice.
            r_state     <= outputs_ready ? WAIT_LOW : IDLE;
          end
        end
        WAIT_LOW: begin
          if (!outputs_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
